// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor helper, 8N1 frame constants and the
// receive/transmit FSM state encoding used by both UART directions.
package uart_pkg;

    // Data bits per 8N1 frame (one start bit, eight data bits, one stop bit).
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int uart_calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with a registered head word. The head register always
// holds the oldest entry, so the read side sees data straight from a flop.
module stream_fifo #(
    parameter int DW = 9,
    parameter int AW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_full,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] head_q, head_d;
    logic          do_wr;
    logic          do_rd;

    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_rd_data = head_q;

    // A write into a full FIFO is accepted only if a pop frees a slot this cycle.
    assign do_rd = i_rd_en && !o_empty;
    assign do_wr = i_wr_en && (!o_full || do_rd);

    // Next pointers and next head: the incoming word becomes head when it will be the only entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        head_d   = head_q;
        if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
            head_d = i_wr_data;
        end else if (rd_ptr_d != wr_ptr_d) begin
            head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array, written without reset.
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/uart_stream_rx.sv
// UART 8N1 receiver: synchronizes the serial pin, reassembles bytes and queues
// them (with an end-of-line flag) for a ready/valid byte-stream consumer.
module uart_stream_rx
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 16000000,
    parameter int         BAUD_RATE   = 57600,
    parameter int         FIFO_AW     = 2,
    parameter logic [7:0] EOL_BYTE    = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int DIV = uart_calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic        sync1_q, sync2_q;
    logic [1:0]  sync_fill_q;
    logic        rx_s;
    logic        armed_q, armed_d;
    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fifo_rd_data;

    assign rx_s = sync2_q;

    // Two-flop synchronizer; sync_fill_q marks when rx_s reflects a real line sample
    // rather than the reset value, so a line held low through reset cannot arm us.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_fill_q <= 2'b00;
        end else begin
            sync1_q     <= i_uart_rx;
            sync2_q     <= sync1_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
        end
    end

    // Receive FSM: next state, baud counter, shift register and flag pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        armed_d     = armed_q | (sync_fill_q[1] & rx_s);
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_FULL;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Return to IDLE mid stop bit so a following start edge is caught.
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overrun_d = push && fifo_full && !pop;
    end

    // FSM and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pop = !fifo_empty && i_tready;

    stream_fifo #(
        .DW (9),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (push),
        .i_wr_data ({(shift_q == EOL_BYTE), shift_q}),
        .o_full    (fifo_full),
        .i_rd_en   (pop),
        .o_rd_data (fifo_rd_data),
        .o_empty   (fifo_empty)
    );

    assign o_tdata     = fifo_rd_data[7:0];
    assign o_tlast     = fifo_rd_data[8];
    assign o_tvalid    = !fifo_empty;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_stream_rx.sv
// Testbench for uart_stream_rx: drives 8N1 frames at the default bit rate and
// checks delivered beats against a queue of expected {tlast, tdata} words.
`timescale 1ns/1ps
module tb_uart_stream_rx;

    localparam int DIV   = (16000000 + 57600 / 2) / 57600;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       tready  = 1'b0;
    logic [7:0] o_tdata;
    logic       o_tlast;
    logic       o_tvalid;
    logic       o_frame_err;
    logic       o_overrun;

    int errors   = 0;
    int checks   = 0;
    int beats    = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int exp_ferr = 0;
    int exp_ovr  = 0;
    logic [8:0] exp_q [$];
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val  = '0;

    uart_stream_rx dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (rx),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .i_tready    (tready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #31 clk = ~clk;

    // Scoreboard monitor: counts flag pulses, checks held data under stall, pops beats.
    always @(negedge clk) begin
        logic [8:0] exp_w;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (o_frame_err === 1'b1) ferr_cnt++;
            if (o_overrun === 1'b1) ovr_cnt++;
            if (stall_prev && o_tvalid === 1'b1) begin
                checks++;
                if ({o_tlast, o_tdata} !== stall_val) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", {o_tlast, o_tdata}, stall_val);
                end
            end
            if (o_tvalid === 1'b1 && tready) begin
                beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%02h last=%b required no beat", o_tdata, o_tlast);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({o_tlast, o_tdata} !== exp_w) begin
                        errors++;
                        $display("FAIL beat: got data=%02h last=%b required data=%02h last=%b",
                                 o_tdata, o_tlast, exp_w[7:0], exp_w[8]);
                    end else begin
                        $display("beat data=%02h last=%b", o_tdata, o_tlast);
                    end
                end
            end
            stall_prev = (o_tvalid === 1'b1) && !tready;
            stall_val  = {o_tlast, o_tdata};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_q.push_back({(d == 8'h0A), d});
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(DIV);
        end
        rx = stop_bit;
        tick(DIV);
        rx = 1'b1;
        $display("sent byte=%02h stop=%0b", d, stop_bit);
    endtask

    task automatic wait_drain(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            tick(1);
        end
        tick(8);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(5);
        checks++; if (o_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h required 00", o_tdata); end
        checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b required 0", o_tlast); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", o_tvalid); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", o_frame_err); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", o_overrun); end
        rst_n = 1'b1;
        tick(10);
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid: got %b required 0", o_tvalid); end
        $display("reset done");
    endtask

    task automatic test_single;
        bit to;
        tready = 1'b1;
        push_exp(8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL single_drain: got %0d pending required 0", exp_q.size()); end
        checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL single_ferr: got %0d required %0d", ferr_cnt, exp_ferr); end
        checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL single_ovr: got %0d required %0d", ovr_cnt, exp_ovr); end
    endtask

    task automatic test_back_to_back;
        bit to;
        logic [7:0] msg [3];
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0A;
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(msg[i]);
            send_frame(msg[i], 1'b1);
        end
        tick(10);
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 8'h4F) begin
            errors++; $display("FAIL b2b_head: got valid=%b data=%02h required valid=1 data=4f", o_tvalid, o_tdata);
        end
        tready = 1'b1;
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
        checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL b2b_ferr: got %0d required %0d", ferr_cnt, exp_ferr); end
    endtask

    task automatic test_overrun;
        bit to;
        tready = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            if (exp_q.size() < DEPTH) push_exp(8'(d));
            else exp_ovr++;
            send_frame(8'(d), 1'b1);
        end
        tick(10);
        checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL overrun_pulses: got %0d required %0d", ovr_cnt, exp_ovr); end
        tready = 1'b1;
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL overrun_drain: got %0d pending required 0", exp_q.size()); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL overrun_empty: got %b required 0", o_tvalid); end
    endtask

    task automatic test_frame_err;
        bit to;
        tready = 1'b1;
        exp_ferr++;
        send_frame(8'hA5, 1'b0);
        tick(2 * DIV);
        checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL frame_err_pulse: got %0d required %0d", ferr_cnt, exp_ferr); end
        push_exp(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL frame_err_next: got %0d pending required 0", exp_q.size()); end
        checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL frame_err_ovr: got %0d required %0d", ovr_cnt, exp_ovr); end
    endtask

    task automatic test_glitch;
        bit to;
        int b0;
        tready = 1'b1;
        b0 = beats;
        rx = 1'b0;
        tick(DIV / 4);
        rx = 1'b1;
        tick(2 * DIV);
        $display("glitch of %0d cycles applied", DIV / 4);
        checks++; if (beats !== b0) begin errors++; $display("FAIL glitch_beat: got %0d beats required %0d", beats, b0); end
        checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
            errors++; $display("FAIL glitch_flags: got ferr=%0d ovr=%0d required ferr=%0d ovr=%0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
        end
        push_exp(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL glitch_recover: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame;
        bit to;
        logic [7:0] d;
        d = 8'h77;
        tready = 1'b0;
        push_exp(8'h11);
        send_frame(8'h11, 1'b1);
        push_exp(8'h22);
        send_frame(8'h22, 1'b1);
        tick(10);
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL midrst_queued: got %b required 1", o_tvalid); end
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            tick(DIV);
        end
        rx = d[3];
        tick(DIV / 2);
        #10;
        rst_n = 1'b0;
        #5;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b required 0", o_tvalid); end
        exp_q.delete();
        rx = 1'b1;
        tick(10);
        rst_n = 1'b1;
        $display("reset applied during bit 3 of 77");
        tick(2 * DIV);
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b required 0", o_tvalid); end
        tready = 1'b1;
        push_exp(8'h12);
        send_frame(8'h12, 1'b1);
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL midrst_next: got %0d pending required 0", exp_q.size()); end
        checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
            errors++; $display("FAIL midrst_flags: got ferr=%0d ovr=%0d required ferr=%0d ovr=%0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
        end
    endtask

    task automatic test_low_through_reset;
        bit to;
        tready = 1'b1;
        rx = 1'b0;
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(3 * DIV);
        rx = 1'b1;
        tick(2 * DIV);
        $display("line held low across reset release");
        push_exp(8'h99);
        send_frame(8'h99, 1'b1);
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL armed_drain: got %0d pending required 0", exp_q.size()); end
        checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
            errors++; $display("FAIL armed_flags: got ferr=%0d ovr=%0d required ferr=%0d ovr=%0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_low_through_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-time bound so the bench always terminates.
    initial begin
        #5500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
